// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word access to a word-wide data memory window.
// Latency: load 2, SW 2, SB/SH 3 (read-modify-write), error 1 cycle from acceptance.
// Backpressure: req_ready only in IDLE; the core holds its request until accepted.
module load_store_unit #(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE_RD,
    S_STORE_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  // Captured request fields; only the byte offset and low store half are needed later.
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        req_err;
  logic        accept;

  // Select the addressed byte/half of a read word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] r;
    r = word;
    if (f3 == F3_B) r[{off, 3'b000} +: 8] = wd[7:0];
    else            r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  // Legality of the presented request: width code, alignment and address window.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = req_addr[0];
      F3_W:        req_err = |req_addr[1:0];
      default:     req_err = 1'b1;
    endcase
    if (req_store && req_funct3[2]) req_err = 1'b1;
    if ((req_addr >> MEM_ADDR_BITS) != 32'd0) req_err = 1'b1;
  end

  assign accept = req_valid && req_ready_q;

  // Sequencer: all outputs are registered so no request input reaches mem_we combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_we_q     <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      wdata_q      <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            funct3_q    <= req_funct3;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (req_err) begin
              // Illegal request never touches memory; answer immediately.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else if (!req_store) begin
              state_q    <= S_LOAD;
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end else if (req_funct3 == F3_W) begin
              state_q     <= S_STORE_WR;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= req_wdata;
              mem_we_q    <= 1'b1;
            end else begin
              state_q    <= S_STORE_RD;
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        S_LOAD: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_extend(mem_rdata, off_q, funct3_q);
        end
        S_STORE_RD: begin
          state_q     <= S_STORE_WR;
          mem_wdata_q <= store_merge(mem_rdata, wdata_q, off_q, funct3_q);
          mem_we_q    <= 1'b1;
        end
        S_STORE_WR: begin
          state_q      <= S_RESP;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          mem_we_q     <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: data memory model, response scoreboard, per-scenario tasks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  int          we_cnt = 0;
  logic [31:0] last_we_data = 32'd0;

  load_store_unit #(.MEM_ADDR_BITS(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[13:2]] = mem_wdata;
      we_cnt++;
      last_we_data = mem_wdata;
    end
  end

  // Scoreboard: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp err=%0b rdata=%h (no request outstanding)", resp_err, resp_rdata);
      end else begin
        e = sb.pop_front();
        if (resp_err !== e.err || resp_rdata !== e.rdata) begin
          bad++;
          $display("FAIL resp got err=%0b rdata=%h want err=%0b rdata=%h", resp_err, resp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Present one request, wait for acceptance and the response; lat counts cycles after acceptance (-1 = none).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  // Independent reference for expected response, latency and memory effect.
  task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output exp_t e, output int lat, output int wes);
    logic        err;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    err = 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) err = 1'b1;
    if (st && f3 >= 3'd4) err = 1'b1;
    if (a >= 32'h4000) err = 1'b1;
    e.err = err; e.rdata = 32'd0; wes = 0;
    if (err) begin lat = 1; return; end
    w  = ref_mem[a[13:2]];
    sh = int'(a[1:0]) * 8;
    b  = 8'((w >> sh) & 32'hFF);
    h  = 16'((w >> (a[1] ? 16 : 0)) & 32'hFFFF);
    if (!st) begin
      lat = 2;
      case (f3)
        3'd0: e.rdata = (b >= 8'h80) ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
        3'd1: e.rdata = (h >= 16'h8000) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
        3'd4: e.rdata = 32'(b);
        3'd5: e.rdata = 32'(h);
        default: e.rdata = w;
      endcase
    end else begin
      wes = 1;
      if (f3 == 3'd2) begin lat = 2; w = wd; end
      else if (f3 == 3'd0) begin lat = 3; w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); end
      else begin lat = 3; sh = a[1] ? 16 : 0; w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); end
      ref_mem[a[13:2]] = w;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp got v=%b e=%b want 0 0", resp_valid, resp_err); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", resp_rdata); end
    total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    int lat;
    exp_t e;
    e.err = 1'b0; e.rdata = 32'h0000000A; sb.push_back(e);
    run_op(1'b0, 3'b010, 32'h2000, 32'd0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", lat); end
  endtask

  task automatic test_store_byte();
    int lat, w0;
    exp_t e;
    w0 = we_cnt;
    e.err = 1'b0; e.rdata = 32'd0; sb.push_back(e);
    run_op(1'b1, 3'b000, 32'h2001, 32'h123456FF, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d want=3", lat); end
    total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL sb_we_pulses got=%0d want=1", we_cnt - w0); end
    total++; if (last_we_data !== 32'h0000FF0A) begin bad++; $display("FAIL sb_wdata got=%h want=0000ff0a", last_we_data); end
    e.rdata = 32'hFFFFFFFF; sb.push_back(e);
    run_op(1'b0, 3'b000, 32'h2001, 32'd0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d want=2", lat); end
    e.rdata = 32'h000000FF; sb.push_back(e);
    run_op(1'b0, 3'b100, 32'h2001, 32'd0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL lbu_latency got=%0d want=2", lat); end
  endtask

  task automatic test_word_half();
    int lat;
    exp_t e;
    e.err = 1'b0; e.rdata = 32'd0; sb.push_back(e);
    run_op(1'b1, 3'b010, 32'h2004, 32'hDEADBEEF, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", lat); end
    e.rdata = 32'hFFFFDEAD; sb.push_back(e);
    run_op(1'b0, 3'b001, 32'h2006, 32'd0, lat);
    e.rdata = 32'h0000BEEF; sb.push_back(e);
    run_op(1'b0, 3'b101, 32'h2004, 32'd0, lat);
    e.rdata = 32'd0; sb.push_back(e);
    run_op(1'b1, 3'b001, 32'h2006, 32'h99991234, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sh_latency got=%0d want=3", lat); end
    e.rdata = 32'h1234BEEF; sb.push_back(e);
    run_op(1'b0, 3'b010, 32'h2004, 32'd0, lat);
  endtask

  task automatic test_errors();
    int lat, w0;
    exp_t e;
    logic        st_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_t [5] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad_t [5] = '{32'h2003, 32'h2002, 32'h4000, 32'h2000, 32'h2000};
    for (int i = 0; i < 5; i++) begin
      w0 = we_cnt;
      e.err = 1'b1; e.rdata = 32'd0; sb.push_back(e);
      run_op(st_t[i], f3_t[i], ad_t[i], 32'hCAFEF00D, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL err%0d_latency got=%0d want=1", i, lat); end
      total++; if (we_cnt !== w0) begin bad++; $display("FAIL err%0d_we got=%0d writes want=0", i, we_cnt - w0); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    e.err = 1'b0; e.rdata = 32'h1234BEEF; sb.push_back(e);
    e.rdata = 32'h00000012; sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2004;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_funct3 = 3'b100; req_addr = 32'h2007;
    total++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_c1 got rdy=%b v=%b want 0 0", req_ready, resp_valid); end
    @(negedge clk);
    total++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_c2 got rdy=%b v=%b want 0 1", req_ready, resp_valid); end
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_c3 got rdy=%b v=%b want 1 0", req_ready, resp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_c4 got rdy=%b want 0", req_ready); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_c5 got v=%b want 1", resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int w0, n;
    mem[32'h2008 >> 2] = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h2008; req_wdata = 32'h0000AAAA;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL abort_outputs got we=%b v=%b want 0 0", mem_we, resp_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", req_ready); end
    total++; if (we_cnt !== w0) begin bad++; $display("FAIL abort_we got=%0d writes want=0", we_cnt - w0); end
    total++; if (mem[32'h2008 >> 2] !== 32'h55667788) begin bad++; $display("FAIL abort_word got=%h want=55667788", mem[32'h2008 >> 2]); end
  endtask

  task automatic test_random();
    logic [2:0] f3_list [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[12'hC00 + i] = v;
      ref_mem[12'hC00 + i] = v;
    end
    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      exp_t        e;
      int          lat, xlat, xwe, w0;
      st = 1'($urandom_range(0, 1));
      f3 = f3_list[$urandom_range(0, 5)];
      a  = 32'h3000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h4000;
      wd = $urandom;
      ref_op(st, f3, a, wd, e, xlat, xwe);
      sb.push_back(e);
      w0 = we_cnt;
      run_op(st, f3, a, wd, lat);
      total++; if (lat !== xlat) begin bad++; $display("FAIL rnd%0d_latency st=%b f3=%0d a=%h got=%0d want=%0d", i, st, f3, a, lat, xlat); end
      total++; if (we_cnt - w0 !== xwe) begin bad++; $display("FAIL rnd%0d_we got=%0d want=%0d", i, we_cnt - w0, xwe); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem[32'h2000 >> 2] = 32'h0000000A;
    test_reset();
    test_load_word();
    test_store_byte();
    test_word_half();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL missing_resp got=%0d outstanding want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
